// File: rtl/vga_timing_gen_pkg.sv
// VGA raster timing constants and phase type.
// Shared by the phase counters, the interface and the top.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam bit SYNC_POL = 1'b0;

   typedef enum logic [1:0] {
      ACTIVE,
      FRONT,
      SYNC,
      BACK
   } phase_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: sync, blanking, coordinates, strobes.
// master = timing source, slave = frame-buffer reader / DAC side.
interface vga_timing_if;
   import vga_timing_pkg::*;

   logic             h_sync;
   logic             v_sync;
   logic             bright;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             line_start;
   logic             frame_start;

   modport master (
      output h_sync, v_sync, bright,
      output pixel_x, pixel_y,
      output line_start, frame_start
   );

   modport slave (
      input h_sync, v_sync, bright,
      input pixel_x, pixel_y,
      input line_start, frame_start
   );

endinterface

// File: rtl/vga_timing_gen_phase.sv
// One raster axis: counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Ports: clk_25, reset_n, step (advance), wrap_en, count, phase, tc.
module vga_phase_counter
   import vga_timing_pkg::*;
#(
   parameter int ACT_LEN  = 640,
   parameter int FP_LEN   = 16,
   parameter int SYNC_LEN = 96,
   parameter int BP_LEN   = 48
) (
   input  logic             clk_25,
   input  logic             reset_n,
   input  logic             step,
   input  logic             wrap_en,
   output logic [CNT_W-1:0] count,
   output phase_t           phase,
   output logic             tc
);

   localparam int L_ACT  = ACT_LEN;
   localparam int L_FP   = L_ACT + FP_LEN;
   localparam int L_SYNC = L_FP + SYNC_LEN;
   localparam int L_ALL  = L_SYNC + BP_LEN;

   localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(L_ACT - 1);
   localparam logic [CNT_W-1:0] END_FP   = CNT_W'(L_FP - 1);
   localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(L_SYNC - 1);
   localparam logic [CNT_W-1:0] END_ALL  = CNT_W'(L_ALL - 1);

   assign tc = (count == END_ALL);

   // Phase register always names the phase of the current count;
   // it changes on the same step that crosses a phase boundary.
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         phase <= ACTIVE;
      end else if (step) begin
         unique case (1'b1)
            tc: begin
               if (wrap_en) begin
                  count <= '0;
                  phase <= ACTIVE;
               end
            end
            (count == END_ACT): begin
               count <= count + 1'b1;
               phase <= FRONT;
            end
            (count == END_FP): begin
               count <= count + 1'b1;
               phase <= SYNC;
            end
            (count == END_SYNC): begin
               count <= count + 1'b1;
               phase <= BACK;
            end
            default: count <= count + 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source (640x480@60 Hz at 25 MHz by default).
// Ports: clk_25, reset_n, enable; vga (master) carries all outputs.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP,
   parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
   input  logic         clk_25,
   input  logic         reset_n,
   input  logic         enable,
   vga_timing_if.master vga
);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   phase_t           h_phase;
   phase_t           v_phase;
   logic             h_tc;
   logic             v_tc;
   logic             v_step;
   logic             origin;

   assign v_step = enable & h_tc;

   vga_phase_counter #(
      .ACT_LEN  (H_ACTIVE),
      .FP_LEN   (H_FP),
      .SYNC_LEN (H_SYNC),
      .BP_LEN   (H_BP)
   ) u_h (
      .clk_25  (clk_25),
      .reset_n (reset_n),
      .step    (enable),
      .wrap_en (1'b1),
      .count   (h_cnt),
      .phase   (h_phase),
      .tc      (h_tc)
   );

   vga_phase_counter #(
      .ACT_LEN  (V_ACTIVE),
      .FP_LEN   (V_FP),
      .SYNC_LEN (V_SYNC),
      .BP_LEN   (V_BP)
   ) u_v (
      .clk_25  (clk_25),
      .reset_n (reset_n),
      .step    (v_step),
      .wrap_en (1'b1),
      .count   (v_cnt),
      .phase   (v_phase),
      .tc      (v_tc)
   );

   // origin tracks "counters sit at (0,0)"; it is set by the
   // joint terminal count so no wide compare is needed.
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         origin <= 1'b1;
      end else if (enable) begin
         origin <= h_tc & v_tc;
      end
   end

   // Outputs describe the position held by the counters one
   // clock earlier; a frozen raster keeps levels, drops strobes.
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         vga.h_sync      <= ~SYNC_POL;
         vga.v_sync      <= ~SYNC_POL;
         vga.bright      <= 1'b0;
         vga.pixel_x     <= '0;
         vga.pixel_y     <= '0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
      end else if (enable) begin
         vga.h_sync      <= (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
         vga.v_sync      <= (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
         vga.bright      <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
         vga.pixel_x     <= h_cnt;
         vga.pixel_y     <= v_cnt;
         vga.line_start  <= (h_cnt == '0);
         vga.frame_start <= origin;
      end else begin
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: full-size and shrunken instances
// checked every cycle against a position-based raster model.
module tb_vga_timing_gen;

   localparam int AH = 640, AHF = 16, AHS = 96, AHB = 48;
   localparam int AV = 480, AVF = 10, AVS = 2, AVB = 33;
   localparam int AHT = AH + AHF + AHS + AHB;
   localparam int AVT = AV + AVF + AVS + AVB;

   localparam int BH = 8, BHF = 2, BHS = 3, BHB = 3;
   localparam int BV = 6, BVF = 2, BVS = 2, BVB = 3;
   localparam int BHT = BH + BHF + BHS + BHB;
   localparam int BVT = BV + BVF + BVS + BVB;

   typedef struct {
      int px;
      int py;
      bit hs;
      bit vs;
      bit br;
      bit ls;
      bit fs;
   } exp_t;

   logic clk_25;
   logic reset_n;
   logic en_a;
   logic en_b;

   int n_pass = 0;
   int n_total = 0;

   vga_timing_if ia ();
   vga_timing_if ib ();

   vga_timing_gen dut_a (
      .clk_25  (clk_25),
      .reset_n (reset_n),
      .enable  (en_a),
      .vga     (ia)
   );

   vga_timing_gen #(
      .H_ACTIVE (BH), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
      .V_ACTIVE (BV), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB),
      .SYNC_POL (1'b0)
   ) dut_b (
      .clk_25  (clk_25),
      .reset_n (reset_n),
      .enable  (en_b),
      .vga     (ib)
   );

   initial begin
      clk_25 = 1'b0;
      forever #20 clk_25 = ~clk_25;
   end

   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // What the outputs must show for raster position (x,y).
   function automatic exp_t at_pos(int x, int y, int ha, int hf, int hs,
                                   int va, int vf, int vs);
      exp_t e;
      e.px = x;
      e.py = y;
      e.br = (x < ha) && (y < va);
      e.hs = !((x >= ha + hf) && (x < ha + hf + hs));
      e.vs = !((y >= va + vf) && (y < va + vf + vs));
      e.ls = (x == 0);
      e.fs = (x == 0) && (y == 0);
      return e;
   endfunction

   function automatic exp_t rst_val();
      exp_t e;
      e.px = 0; e.py = 0;
      e.hs = 1'b1; e.vs = 1'b1;
      e.br = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
      return e;
   endfunction

   int   ma_x, ma_y, mb_x, mb_y;
   exp_t ma_o, mb_o;

   always @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         ma_x <= 0;
         ma_y <= 0;
         ma_o <= rst_val();
      end else if (en_a) begin
         ma_o <= at_pos(ma_x, ma_y, AH, AHF, AHS, AV, AVF, AVS);
         ma_x <= (ma_x + 1) % AHT;
         if (ma_x == AHT - 1) ma_y <= (ma_y + 1) % AVT;
      end else begin
         ma_o.ls <= 1'b0;
         ma_o.fs <= 1'b0;
      end
   end

   always @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         mb_x <= 0;
         mb_y <= 0;
         mb_o <= rst_val();
      end else if (en_b) begin
         mb_o <= at_pos(mb_x, mb_y, BH, BHF, BHS, BV, BVF, BVS);
         mb_x <= (mb_x + 1) % BHT;
         if (mb_x == BHT - 1) mb_y <= (mb_y + 1) % BVT;
      end else begin
         mb_o.ls <= 1'b0;
         mb_o.fs <= 1'b0;
      end
   end

   task automatic cmp(input string t, input exp_t e,
                      input logic hs, input logic vs, input logic br,
                      input int px, input int py,
                      input logic ls, input logic fs);
      chk({t, ".h_sync"}, int'(hs), int'(e.hs));
      chk({t, ".v_sync"}, int'(vs), int'(e.vs));
      chk({t, ".bright"}, int'(br), int'(e.br));
      chk({t, ".pixel_x"}, px, e.px);
      chk({t, ".pixel_y"}, py, e.py);
      chk({t, ".line_start"}, int'(ls), int'(e.ls));
      chk({t, ".frame_start"}, int'(fs), int'(e.fs));
   endtask

   always @(negedge clk_25) begin
      cmp("a", ma_o, ia.h_sync, ia.v_sync, ia.bright,
          int'(ia.pixel_x), int'(ia.pixel_y),
          ia.line_start, ia.frame_start);
      cmp("b", mb_o, ib.h_sync, ib.v_sync, ib.bright,
          int'(ib.pixel_x), int'(ib.pixel_y),
          ib.line_start, ib.frame_start);
   end

   task automatic cyc();
      @(negedge clk_25);
      #2;
   endtask

   int br_cnt, hs_cnt, first_low, ls_cnt, vs_cnt, fs_cnt, first_vy;
   bit found;

   initial begin
      reset_n = 1'b0;
      en_a = 1'b1;
      en_b = 1'b1;
      repeat (3) cyc();
      chk("rst.h_sync", int'(ia.h_sync), 1);
      chk("rst.bright", int'(ia.bright), 0);
      chk("rst.frame_start", int'(ia.frame_start), 0);
      chk("rst.pixel_x", int'(ia.pixel_x), 0);

      reset_n = 1'b1;
      cyc();
      chk("first.frame_start", int'(ia.frame_start), 1);
      chk("first.line_start", int'(ia.line_start), 1);
      chk("first.pixel_x", int'(ia.pixel_x), 0);
      chk("first.pixel_y", int'(ia.pixel_y), 0);
      chk("first.bright", int'(ia.bright), 1);
      chk("first.h_sync", int'(ia.h_sync), 1);
      chk("first.v_sync", int'(ia.v_sync), 1);

      br_cnt = 0; hs_cnt = 0; ls_cnt = 0; first_low = -1;
      for (int i = 0; i < 800; i++) begin
         if (ia.bright) br_cnt++;
         if (ia.line_start) ls_cnt++;
         if (!ia.h_sync) begin
            hs_cnt++;
            if (first_low < 0) first_low = int'(ia.pixel_x);
         end
         cyc();
      end
      chk("line.bright_clocks", br_cnt, 640);
      chk("line.hsync_clocks", hs_cnt, 96);
      chk("line.hsync_first_x", first_low, 656);
      chk("line.strobes_in_800", ls_cnt, 1);
      chk("line.next_strobe", int'(ia.line_start), 1);
      chk("line.next_y", int'(ia.pixel_y), 1);

      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (ia.pixel_x == 10'd300) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      chk("wait.x300", int'(found), 1);
      en_a = 1'b0;
      repeat (50) cyc();
      chk("freeze.pixel_x", int'(ia.pixel_x), 300);
      chk("freeze.pixel_y", int'(ia.pixel_y), 1);
      chk("freeze.bright", int'(ia.bright), 1);
      chk("freeze.line_start", int'(ia.line_start), 0);
      en_a = 1'b1;
      cyc();
      chk("resume.pixel_x", int'(ia.pixel_x), 301);

      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (ia.pixel_x == 10'd700) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      chk("wait.x700", int'(found), 1);
      chk("pre_rst.h_sync", int'(ia.h_sync), 0);
      reset_n = 1'b0;
      #1;
      chk("async.pixel_x", int'(ia.pixel_x), 0);
      chk("async.pixel_y", int'(ia.pixel_y), 0);
      chk("async.h_sync", int'(ia.h_sync), 1);
      chk("async.b_pixel_x", int'(ib.pixel_x), 0);
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc();
      chk("restart.frame_start", int'(ia.frame_start), 1);
      chk("restart.pixel_x", int'(ia.pixel_x), 0);
      chk("restart.pixel_y", int'(ia.pixel_y), 0);

      vs_cnt = 0; br_cnt = 0; fs_cnt = 0; first_vy = -1;
      for (int i = 0; i < BHT * BVT; i++) begin
         if (ib.bright) br_cnt++;
         if (ib.frame_start) fs_cnt++;
         if (!ib.v_sync) begin
            vs_cnt++;
            if (first_vy < 0) first_vy = int'(ib.pixel_y);
         end
         cyc();
      end
      chk("frame.vsync_clocks", vs_cnt, 32);
      chk("frame.bright_clocks", br_cnt, 48);
      chk("frame.vsync_first_y", first_vy, 8);
      chk("frame.strobes", fs_cnt, 1);
      chk("frame.next_strobe", int'(ib.frame_start), 1);

      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (ib.pixel_x == 10'd15 && ib.pixel_y == 10'd12) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      chk("wait.corner", int'(found), 1);
      cyc();
      chk("wrap.pixel_x", int'(ib.pixel_x), 0);
      chk("wrap.pixel_y", int'(ib.pixel_y), 0);
      chk("wrap.line_start", int'(ib.line_start), 1);
      chk("wrap.frame_start", int'(ib.frame_start), 1);

      en_b = 1'b0;
      cyc();
      chk("hold.line_start", int'(ib.line_start), 0);
      chk("hold.frame_start", int'(ib.frame_start), 0);
      chk("hold.pixel_x", int'(ib.pixel_x), 0);
      en_b = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         en_a = ($urandom_range(0, 3) != 0);
         en_b = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 699) == 0) reset_n = 1'b0;
         else reset_n = 1'b1;
         cyc();
      end
      reset_n = 1'b1;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
